// File: rtl/change_dispenser_if.sv
// Handshake and status bundle between the vending controller and the change dispenser.
interface change_dispenser_if;
  logic       start;
  logic [7:0] amount;
  logic       busy;
  logic       coin_25_out;
  logic       coin_10_out;
  logic       coin_5_out;
  logic [3:0] coin_count;
  logic [7:0] remaining;
  logic       remainder_err;
  logic       done;

  modport master (
    output start, amount,
    input  busy, coin_25_out, coin_10_out, coin_5_out,
    input  coin_count, remaining, remainder_err, done
  );

  modport slave (
    input  start, amount,
    output busy, coin_25_out, coin_10_out, coin_5_out,
    output coin_count, remaining, remainder_err, done
  );
endinterface

// File: rtl/change_dispenser.sv
// Pays a latched change amount as greedy 25c/10c/5c ejector pulses separated by fixed gaps.
// All outputs come straight from flops so the ejector lines never glitch.
module change_dispenser #(
  parameter int PULSE_CYCLES = 12_500_000,
  parameter int GAP_CYCLES   = 12_500_000,
  parameter int TMR_W        = 24
) (
  input  logic                clk,
  input  logic                reset,
  change_dispenser_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_PULSE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);

  state_t           state_r, state_nxt_s;
  logic [TMR_W-1:0] timer_r, timer_nxt_s;
  logic [7:0]       remaining_r, remaining_nxt_s;
  logic [3:0]       count_r, count_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             err_r, err_nxt_s;
  logic             done_r, done_nxt_s;
  logic             c25_r, c25_nxt_s;
  logic             c10_r, c10_nxt_s;
  logic             c5_r, c5_nxt_s;

  // State and registered-output flops; async reset drops coin lines at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      timer_r     <= {TMR_W{1'b0}};
      remaining_r <= 8'd0;
      count_r     <= 4'd0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
      done_r      <= 1'b0;
      c25_r       <= 1'b0;
      c10_r       <= 1'b0;
      c5_r        <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      timer_r     <= timer_nxt_s;
      remaining_r <= remaining_nxt_s;
      count_r     <= count_nxt_s;
      busy_r      <= busy_nxt_s;
      err_r       <= err_nxt_s;
      done_r      <= done_nxt_s;
      c25_r       <= c25_nxt_s;
      c10_r       <= c10_nxt_s;
      c5_r        <= c5_nxt_s;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead.
  always_comb begin
    state_nxt_s     = state_r;
    timer_nxt_s     = timer_r;
    remaining_nxt_s = remaining_r;
    count_nxt_s     = count_r;
    busy_nxt_s      = busy_r;
    err_nxt_s       = err_r;
    done_nxt_s      = 1'b0;
    c25_nxt_s       = c25_r;
    c10_nxt_s       = c10_r;
    c5_nxt_s        = c5_r;

    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          remaining_nxt_s = bus.amount;
          count_nxt_s     = 4'd0;
          err_nxt_s       = 1'b0;
          busy_nxt_s      = 1'b1;
          state_nxt_s     = ST_SELECT;
        end else begin
          state_nxt_s     = ST_IDLE;
        end
      end

      ST_SELECT: begin
        if (remaining_r >= 8'd25) begin
          c25_nxt_s       = 1'b1;
          remaining_nxt_s = remaining_r - 8'd25;
          count_nxt_s     = count_r + 4'd1;
          timer_nxt_s     = PULSE_LOAD;
          state_nxt_s     = ST_PULSE;
        end else if (remaining_r >= 8'd10) begin
          c10_nxt_s       = 1'b1;
          remaining_nxt_s = remaining_r - 8'd10;
          count_nxt_s     = count_r + 4'd1;
          timer_nxt_s     = PULSE_LOAD;
          state_nxt_s     = ST_PULSE;
        end else if (remaining_r >= 8'd5) begin
          c5_nxt_s        = 1'b1;
          remaining_nxt_s = remaining_r - 8'd5;
          count_nxt_s     = count_r + 4'd1;
          timer_nxt_s     = PULSE_LOAD;
          state_nxt_s     = ST_PULSE;
        end else begin
          done_nxt_s      = 1'b1;
          state_nxt_s     = ST_DONE;
        end
      end

      ST_PULSE: begin
        if (timer_r == {TMR_W{1'b0}}) begin
          c25_nxt_s   = 1'b0;
          c10_nxt_s   = 1'b0;
          c5_nxt_s    = 1'b0;
          timer_nxt_s = GAP_LOAD;
          state_nxt_s = ST_GAP;
        end else begin
          timer_nxt_s = timer_r - {{(TMR_W-1){1'b0}}, 1'b1};
        end
      end

      ST_GAP: begin
        if (timer_r == {TMR_W{1'b0}}) begin
          state_nxt_s = ST_SELECT;
        end else begin
          timer_nxt_s = timer_r - {{(TMR_W-1){1'b0}}, 1'b1};
        end
      end

      ST_DONE: begin
        err_nxt_s   = (remaining_r != 8'd0);
        busy_nxt_s  = 1'b0;
        state_nxt_s = ST_IDLE;
      end

      default: begin
        state_nxt_s = ST_IDLE;
        busy_nxt_s  = 1'b0;
        c25_nxt_s   = 1'b0;
        c10_nxt_s   = 1'b0;
        c5_nxt_s    = 1'b0;
        timer_nxt_s = {TMR_W{1'b0}};
      end
    endcase
  end

  assign bus.busy          = busy_r;
  assign bus.coin_25_out   = c25_r;
  assign bus.coin_10_out   = c10_r;
  assign bus.coin_5_out    = c5_r;
  assign bus.coin_count    = count_r;
  assign bus.remaining     = remaining_r;
  assign bus.remainder_err = err_r;
  assign bus.done          = done_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser; expected waveforms come from a greedy coin-list model.
module tb_change_dispenser;
  localparam int P   = 3;
  localparam int G   = 2;
  localparam int PER = 1 + P + G;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  change_dispenser_if dif ();

  change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .TMR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [17:0] observe();
    return {dif.busy, dif.coin_25_out, dif.coin_10_out, dif.coin_5_out, dif.done,
            dif.remainder_err, dif.coin_count, dif.remaining};
  endfunction

  // One payout, checked cycle by cycle; optionally fires an extra start mid-payout.
  task automatic payout(input int amt, input int extra_j_in, input int extra_amt);
    int coins[$];
    int r, k, dj, ni, rem, extra_j;
    logic c25, c10, c5;
    logic [17:0] expv;
    string tag;
    r = amt;
    while (r >= 25) begin coins.push_back(25); r -= 25; end
    while (r >= 10) begin coins.push_back(10); r -= 10; end
    while (r >= 5)  begin coins.push_back(5);  r -= 5;  end
    k  = coins.size();
    dj = 2 + PER * k;
    extra_j = (extra_j_in > dj) ? 0 : extra_j_in;

    @(negedge clk);
    dif.start  = 1'b1;
    dif.amount = amt[7:0];
    @(negedge clk);
    dif.start  = 1'b0;
    for (int j = 1; j <= dj + 1; j++) begin
      if (j > 1) @(negedge clk);
      ni  = 0;
      rem = amt;
      c25 = 1'b0; c10 = 1'b0; c5 = 1'b0;
      for (int i = 0; i < k; i++) begin
        if (1 + PER * i < j) begin ni++; rem -= coins[i]; end
        if (j >= 2 + PER * i && j <= 1 + PER * i + P) begin
          if (coins[i] == 25) c25 = 1'b1;
          else if (coins[i] == 10) c10 = 1'b1;
          else c5 = 1'b1;
        end
      end
      expv = {(j <= dj), c25, c10, c5, (j == dj), ((j > dj) && (r != 0)),
              4'(ni), 8'(rem)};
      tag = $sformatf("amt%0d_cyc%0d", amt, j);
      chk(tag, 32'(observe()), 32'(expv));
      if (j == extra_j) begin
        dif.start  = 1'b1;
        dif.amount = extra_amt[7:0];
      end else begin
        dif.start  = 1'b0;
      end
    end
    dif.start = 1'b0;
  endtask

  // Reset asserted while a quarter pulse is high must clear every output at once.
  task automatic reset_mid_pulse();
    @(negedge clk);
    dif.start  = 1'b1;
    dif.amount = 8'd40;
    @(negedge clk);
    dif.start  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_pulse", 32'(dif.coin_25_out), 32'd1);
    #2 reset = 1'b1;
    #1 chk("rst_async_clear", 32'(observe()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_after_release", 32'(observe()), 32'd0);
  endtask

  initial begin
    int amt, ej;
    reset      = 1'b1;
    dif.start  = 1'b0;
    dif.amount = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'(observe()), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", 32'(observe()), 32'd0);

    payout(40, 0, 0);
    payout(0, 0, 0);
    payout(7, 0, 0);
    payout(7, 0, 0);
    payout(255, 0, 0);
    payout(25, 3, 100);
    reset_mid_pulse();
    payout(40, 0, 0);
    payout(4, 2, 200);

    for (int t = 0; t < 20; t++) begin
      amt = int'($urandom_range(0, 255));
      ej  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 20));
      payout(amt, ej, int'($urandom_range(0, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
